rgb_sequencer: RTL and testbench
================================

Name: rgb_sequencer

Overview:
Parametrised RGB colour-cycling light controller.
- Steps through a fixed 6-colour wheel: red, yellow, green, cyan, blue, magenta.
- Programmable dwell time per colour, programmable brightness level, and selectable direction.
- Supports start, stop and pause/resume control.
- Drives the board RGB LED channels and is the successor to the fixed-width, one-colour-per-clock light FSM.

Parameters:
CW, 4, width of each colour channel (brightness resolution).
DIV_W, 8, width of the dwell input and of the dwell counter.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  level; begin from OFF, or resume from PAUSED.
stop  input  1  level; go to OFF (all channels dark).
pause  input  1  level; freeze the sequence in RUN.
dwell  input  DIV_W  cycles per colour minus 1 (0 = advance every cycle).
level  input  CW  on-intensity applied to every active channel.
dir  input  1  0 = forward through the wheel, 1 = reverse.
r  output  CW  red channel.
g  output  CW  green channel.
b  output  CW  blue channel.
running  output  1  1 while in RUN.
step_idx  output  3  current colour index, 0..5.

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clock.
- Values on reset: state OFF, step_idx 0, dwell counter 0, r/g/b 0, running 0.
- States: OFF, RUN, PAUSED. Control priority is stop > pause > start.
- OFF:
  - start=1 and stop=0 -> RUN, with step_idx 0 and counter 0.
  - Otherwise stay in OFF.
- RUN:
  - stop=1 -> OFF, step_idx 0, counter 0.
  - Else pause=1 -> PAUSED; counter and step_idx are held.
  - Else the counter increments each cycle.
  - When counter >= dwell: counter <- 0 and step_idx advances.
    - dir=0: 0->1->...->5->0.
    - dir=1: 5->4->...->0->5.
  - Using >= means lowering dwell mid-step expires the step on the next cycle. The counter never passes 2^DIV_W-1.
- PAUSED:
  - stop=1 -> OFF.
  - Else start=1 and pause=0 -> RUN; the counter resumes from its held value.
  - Else stay in PAUSED.
- Colour map for active channels (each active channel = level, inactive = 0):
  - 0: R
  - 1: R+G
  - 2: G
  - 3: G+B
  - 4: B
  - 5: R+B
- Output timing:
  - r/g/b and running are registered, loaded on each edge from next_state, next step_idx and the current level.
  - A level change is therefore visible one cycle later.
  - Outputs are never combinational from inputs.
- OFF outputs: r/g/b forced to 0.
- PAUSED outputs: the current colour is held at the current level (see optional feature).
- step_idx is the registered index; it is always in 0..5. Any illegal value recovers to 0 on the next edge.
- Simultaneous start+stop: stop wins; the block stays in or goes to OFF.
- dir may change at any time; it takes effect at the next step advance.
- Reset mid-sequence: immediate OFF with all outputs 0. There is no resume memory after reset.

Optional Feature:
Macro RGB_SEQ_PAUSE_BLINK_EN.
- Defined:
  - In PAUSED, the held colour blinks. A blink phase bit toggles each time the counter-like blink timer reaches dwell; the timer is separate and the step counter stays frozen.
  - Phase 1 shows the colour at level; phase 0 shows all 0.
  - The phase resets to 1 on entry to PAUSED.
- Undefined: PAUSED holds the colour steady. No blink timer is synthesised.

Test Plan:
- Reset assert mid-RUN -> r=g=b=0, running=0, step_idx=0 in the same cycle (asynchronous).
- start pulse, dwell=0, level=4'hF, dir=0 -> r/g/b sequence F00, FF0, 0F0, 0FF, 00F, F0F, then F00 (wrap), one colour per cycle.
- dwell=3, dir=1 -> each colour held 4 cycles; order is idx 0, 5, 4, 3, ...; running=1 throughout.
- RUN at idx 2, pause=1 for 10 cycles, then start -> idx 2 held (0F0), counter resumes; the total dwell of idx 2 equals dwell+1 active cycles.
- start=1 and stop=1 together from OFF -> stays OFF with outputs 0. stop during PAUSED -> OFF, and the next start begins at idx 0.
- level changes from F to 3 in RUN -> outputs show 3 on active channels one cycle later. Drop dwell from 200 to 5 with counter=50 -> step advances on the next cycle.

Source files
------------

// File: rtl/rgb_sequencer.sv
// rtl/rgb_sequencer.sv - six-colour RGB wheel sequencer with dwell, level, direction and pause.
// Define RGB_SEQ_PAUSE_BLINK_EN to blink the held colour while PAUSED.
module rgb_sequencer #(
  parameter int CW    = 4,
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [DIV_W-1:0] dwell,
  input  logic [CW-1:0]    level,
  input  logic             dir,
  output logic [CW-1:0]    r,
  output logic [CW-1:0]    g,
  output logic [CW-1:0]    b,
  output logic             running,
  output logic [2:0]       step_idx
);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [2:0]       r_step;
  logic [2:0]       w_next_step;
  logic [2:0]       w_step_ok;
  logic [2:0]       w_step_adv;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_next_cnt;
  logic [CW-1:0]    r_red;
  logic [CW-1:0]    r_grn;
  logic [CW-1:0]    r_blu;
  logic             r_running;
  logic [2:0]       w_mask;
  logic             w_show;

  // An out-of-range index is treated as colour 0 so it recovers on the next edge.
  always_comb begin
    w_step_ok = (r_step > 3'd5) ? 3'd0 : r_step;
    if (dir) w_step_adv = (w_step_ok == 3'd0) ? 3'd5 : w_step_ok - 3'd1;
    else     w_step_adv = (w_step_ok == 3'd5) ? 3'd0 : w_step_ok + 3'd1;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_step  = w_step_ok;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_next_state = S_OFF;
          w_next_step  = 3'd0;
          w_next_cnt   = '0;
        end else if (pause) begin
          w_next_state = S_PAUSED;
        end else if (r_cnt >= dwell) begin
          w_next_cnt  = '0;
          w_next_step = w_step_adv;
        end else begin
          w_next_cnt = r_cnt + DIV_W'(1);
        end
      end
      S_PAUSED: begin
        if (stop) begin
          w_next_state = S_OFF;
          w_next_step  = 3'd0;
          w_next_cnt   = '0;
        end else if (start && !pause) begin
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = (start && !stop) ? S_RUN : S_OFF;
        w_next_step  = 3'd0;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Bit order {R,G,B}.
  always_comb begin
    case (w_next_step)
      3'd0:    w_mask = 3'b100;
      3'd1:    w_mask = 3'b110;
      3'd2:    w_mask = 3'b010;
      3'd3:    w_mask = 3'b011;
      3'd4:    w_mask = 3'b001;
      3'd5:    w_mask = 3'b101;
      default: w_mask = 3'b000;
    endcase
  end

`ifdef RGB_SEQ_PAUSE_BLINK_EN
  logic             r_blink_phase;
  logic             w_next_phase;
  logic [DIV_W-1:0] r_blink_cnt;
  logic [DIV_W-1:0] w_next_blink_cnt;

  always_comb begin
    w_next_phase     = 1'b1;
    w_next_blink_cnt = '0;
    if (w_next_state == S_PAUSED && r_state == S_PAUSED) begin
      if (r_blink_cnt >= dwell) begin
        w_next_phase = ~r_blink_phase;
      end else begin
        w_next_phase     = r_blink_phase;
        w_next_blink_cnt = r_blink_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink_phase <= 1'b1;
      r_blink_cnt   <= '0;
    end else begin
      r_blink_phase <= w_next_phase;
      r_blink_cnt   <= w_next_blink_cnt;
    end
  end

  assign w_show = (w_next_state != S_OFF) && ((w_next_state != S_PAUSED) || w_next_phase);
`else
  assign w_show = (w_next_state != S_OFF);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_OFF;
      r_step    <= 3'd0;
      r_cnt     <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_step    <= w_next_step;
      r_cnt     <= w_next_cnt;
      r_red     <= (w_show && w_mask[2]) ? level : '0;
      r_grn     <= (w_show && w_mask[1]) ? level : '0;
      r_blu     <= (w_show && w_mask[0]) ? level : '0;
      r_running <= (w_next_state == S_RUN);
    end
  end

  assign r        = r_red;
  assign g        = r_grn;
  assign b        = r_blu;
  assign running  = r_running;
  assign step_idx = r_step;

endmodule

// File: tb/tb_rgb_sequencer.sv
// tb/tb_rgb_sequencer.sv - self-checking bench for rgb_sequencer (default build, steady pause).
module tb_rgb_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic       dir   = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] level = 4'hF;
  logic [3:0] r, g, b;
  logic       running;
  logic [2:0] step_idx;

  rgb_sequencer #(.CW(4), .DIV_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .dwell(dwell), .level(level), .dir(dir),
    .r(r), .g(g), .b(b), .running(running), .step_idx(step_idx)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=OFF 1=RUN 2=PAUSED; wheel position and elapsed cycles as plain integers.
  int red_on[6] = '{1, 1, 0, 0, 0, 1};
  int grn_on[6] = '{0, 1, 1, 1, 0, 0};
  int blu_on[6] = '{0, 0, 0, 1, 1, 1};
  int m_mode, m_idx, m_cnt, m_level;
  int e_r, e_g, e_b;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_level = 0;
    end else begin
      m_level = int'(level);
      if (m_mode == 0) begin
        if (start && !stop) begin m_mode = 1; m_idx = 0; m_cnt = 0; end
      end else if (stop) begin
        m_mode = 0; m_idx = 0; m_cnt = 0;
      end else if (m_mode == 1) begin
        if (pause) m_mode = 2;
        else if (m_cnt >= int'(dwell)) begin
          m_cnt = 0;
          m_idx = dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
        end else m_cnt = m_cnt + 1;
      end else if (start && !pause) begin
        m_mode = 1;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (!reset) begin
      e_r = (m_mode != 0 && red_on[m_idx] == 1) ? m_level : 0;
      e_g = (m_mode != 0 && grn_on[m_idx] == 1) ? m_level : 0;
      e_b = (m_mode != 0 && blu_on[m_idx] == 1) ? m_level : 0;
      chk("model_r", 32'(r), 32'(e_r));
      chk("model_g", 32'(g), 32'(e_g));
      chk("model_b", 32'(b), 32'(e_b));
      chk("model_running", 32'(running), (m_mode == 1) ? 32'd1 : 32'd0);
      chk("model_step_idx", 32'(step_idx), 32'(m_idx));
    end
  end

  logic [11:0] wheel[7] = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'hF0F, 12'hF00};
  int          rev_idx[3] = '{0, 5, 4};

  task automatic tick;
    @(posedge clock);
    #3;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tick();
    chk("reset_rgb", 32'({r, g, b}), 32'h0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_step", 32'(step_idx), 32'd0);

    // Forward wheel, one colour per cycle.
    @(negedge clock); start = 1'b1; dwell = 8'd0; level = 4'hF; dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wheel_rgb", 32'({r, g, b}), 32'(wheel[i]));
      chk("wheel_step", 32'(step_idx), 32'(i % 6));
    end
    @(negedge clock); start = 1'b0; stop = 1'b1;
    tick();
    chk("stop_rgb", 32'({r, g, b}), 32'h0);
    chk("stop_running", 32'(running), 32'd0);

    // Reverse with 4 cycles per colour.
    @(negedge clock); stop = 1'b0; start = 1'b1; dwell = 8'd3; dir = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rev_step", 32'(step_idx), 32'(rev_idx[i / 4]));
      chk("rev_running", 32'(running), 32'd1);
    end

    // Pause at idx 2 with one cycle already elapsed.
    @(negedge clock); start = 1'b0; stop = 1'b1; dir = 1'b0;
    @(negedge clock); stop = 1'b0; start = 1'b1;
    repeat (10) @(posedge clock);
    #3;
    chk("prepause_step", 32'(step_idx), 32'd2);
    @(negedge clock); pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_rgb", 32'({r, g, b}), 32'h0F0);
      chk("pause_running", 32'(running), 32'd0);
    end
    @(negedge clock); pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("resume_step", 32'(step_idx), 32'd2);
    end
    tick();
    chk("resume_advance", 32'(step_idx), 32'd3);

    // start and stop together from OFF.
    @(negedge clock); stop = 1'b1; start = 1'b1;
    repeat (3) begin
      tick();
      chk("startstop_rgb", 32'({r, g, b}), 32'h0);
      chk("startstop_running", 32'(running), 32'd0);
    end

    // stop during PAUSED, restart at idx 0.
    @(negedge clock); stop = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    chk("run_step1", 32'(step_idx), 32'd1);
    @(negedge clock); pause = 1'b1;
    @(negedge clock); pause = 1'b0; start = 1'b0; stop = 1'b1;
    tick();
    chk("pstop_rgb", 32'({r, g, b}), 32'h0);
    chk("pstop_step", 32'(step_idx), 32'd0);
    @(negedge clock); stop = 1'b0; start = 1'b1;
    tick();
    chk("restart_rgb", 32'({r, g, b}), 32'hF00);
    chk("restart_step", 32'(step_idx), 32'd0);

    // Level change and dwell drop mid-step.
    @(negedge clock); stop = 1'b1; start = 1'b0;
    @(negedge clock); stop = 1'b0; start = 1'b1; dwell = 8'd200;
    repeat (51) @(posedge clock);
    #3;
    chk("long_rgb", 32'({r, g, b}), 32'hF00);
    @(negedge clock); level = 4'h3;
    tick();
    chk("level_rgb", 32'({r, g, b}), 32'h300);
    @(negedge clock); dwell = 8'd5;
    tick();
    chk("dwell_drop_step", 32'(step_idx), 32'd1);
    chk("dwell_drop_rgb", 32'({r, g, b}), 32'h330);

    // Asynchronous reset mid-RUN.
    @(posedge clock); #3; reset = 1'b1;
    #1;
    chk("areset_rgb", 32'({r, g, b}), 32'h0);
    chk("areset_running", 32'(running), 32'd0);
    chk("areset_step", 32'(step_idx), 32'd0);
    @(negedge clock); start = 1'b0;
    @(negedge clock); reset = 1'b0;
    tick();
    chk("post_reset_running", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
